// File: rtl/fp_div_seq_pkg.sv
// Shared FP types: FSM state encoding, status-flag bundle and format helpers.
package fp_div_seq_pkg;

    localparam int FP_EXP_DEFAULT = 8;
    localparam int FP_MAN_DEFAULT = 23;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } fp_state_e;

    typedef struct packed {
        logic inf;
        logic nan;
        logic zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return 2 ** (exp_w - 1) - 1;
    endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// Request/response bundle for the sequential FP divider.
interface fp_div_seq_if
    import fp_div_seq_pkg::*;
#(
    parameter int EXP = FP_EXP_DEFAULT,
    parameter int MAN = FP_MAN_DEFAULT
);
    localparam int BITS = MAN + EXP + 1;

    logic            start;
    logic [BITS-1:0] X;
    logic [BITS-1:0] Y;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic            inf;
    logic            nan;
    logic            zero;
    logic            overflow;
    logic            underflow;

    modport master (
        output start, X, Y,
        input  busy, done, result, inf, nan, zero, overflow, underflow
    );

    modport slave (
        input  start, X, Y,
        output busy, done, result, inf, nan, zero, overflow, underflow
    );

endinterface

// File: rtl/fp_div_seq_classify.sv
// Per-operand classification; exponent 0 is flushed to zero (no denormals).
module fp_div_seq_classify #(
    parameter int EXP = 8,
    parameter int MAN = 23
) (
    input  logic [EXP-1:0] exp_i,
    input  logic [MAN-1:0] frac_i,
    output logic           is_zero_o,
    output logic           is_inf_o,
    output logic           is_nan_o
);

    logic exp_ones;

    assign exp_ones  = (exp_i == '1);
    assign is_zero_o = (exp_i == '0);
    assign is_inf_o  = exp_ones && (frac_i == '0);
    assign is_nan_o  = exp_ones && (frac_i != '0);

endmodule

// File: rtl/fp_div_seq.sv
// Sequential FP divider: radix-2 restoring mantissa division, one quotient bit per clock.
module fp_div_seq
    import fp_div_seq_pkg::*;
#(
    parameter int EXP = FP_EXP_DEFAULT,
    parameter int MAN = FP_MAN_DEFAULT
) (
    input logic        clk,
    input logic        reset,
    fp_div_seq_if.slave bus
);

    localparam int BITS = MAN + EXP + 1;
    localparam int BIAS = fp_bias(EXP);
    localparam int CW   = $clog2(MAN + 2);
    localparam logic [EXP-1:0]  E_B  = '1;
    localparam logic [BITS-1:0] QNAN = {1'b0, E_B, 1'b1, {(MAN-1){1'b0}}};

    fp_state_e              state_q, state_d;
    logic                   sign_q, sign_d;
    logic [MAN+2:0]         rem_q, rem_d;
    logic [MAN:0]           dvs_q, dvs_d;
    logic [MAN+1:0]         quo_q, quo_d;
    logic signed [EXP+1:0]  exp_q, exp_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BITS-1:0]        res_q, res_d;
    fp_flags_t              flg_q, flg_d;

    logic x_zero, x_inf, x_nan;
    logic y_zero, y_inf, y_nan;
    logic nan_case, inf_case, is_special;

    logic signed [EXP+1:0]  exp_n;
    logic [MAN-1:0]         frac_n;
    logic                   ovf_n, unf_n;
    logic [MAN+2:0]         dvs_ext;

    fp_div_seq_classify #(.EXP(EXP), .MAN(MAN)) u_cls_x (
        .exp_i     (bus.X[BITS-2:MAN]),
        .frac_i    (bus.X[MAN-1:0]),
        .is_zero_o (x_zero),
        .is_inf_o  (x_inf),
        .is_nan_o  (x_nan)
    );

    fp_div_seq_classify #(.EXP(EXP), .MAN(MAN)) u_cls_y (
        .exp_i     (bus.Y[BITS-2:MAN]),
        .frac_i    (bus.Y[MAN-1:0]),
        .is_zero_o (y_zero),
        .is_inf_o  (y_inf),
        .is_nan_o  (y_nan)
    );

    // Priority: NaN cases first, then infinities, remaining specials are zero results.
    assign nan_case   = x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf);
    assign inf_case   = x_inf || y_zero;
    assign is_special = nan_case || inf_case || x_zero || y_inf;

    assign dvs_ext = {2'b00, dvs_q};

    always_comb begin
        if (quo_q[MAN+1]) begin
            exp_n  = exp_q;
            frac_n = quo_q[MAN:1];
        end else begin
            exp_n  = exp_q - (EXP+2)'(1);
            frac_n = quo_q[MAN-1:0];
        end
    end

    assign ovf_n = !exp_n[EXP+1] && (exp_n[EXP:0] >= (EXP+1)'(2 ** EXP - 1));
    assign unf_n = exp_n[EXP+1] || (exp_n == '0);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flg_d   = flg_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d = bus.X[BITS-1] ^ bus.Y[BITS-1];
                    if (is_special) begin
                        state_d = DONE;
                        flg_d   = '0;
                        if (nan_case) begin
                            res_d     = QNAN;
                            flg_d.nan = 1'b1;
                        end else if (inf_case) begin
                            res_d     = {sign_d, E_B, {MAN{1'b0}}};
                            flg_d.inf = 1'b1;
                        end else begin
                            res_d      = {sign_d, {(BITS-1){1'b0}}};
                            flg_d.zero = 1'b1;
                        end
                    end else begin
                        state_d = DIV;
                        rem_d   = {2'b00, 1'b1, bus.X[MAN-1:0]};
                        dvs_d   = {1'b1, bus.Y[MAN-1:0]};
                        quo_d   = '0;
                        cnt_d   = '0;
                        exp_d   = $signed({2'b00, bus.X[BITS-2:MAN]})
                                - $signed({2'b00, bus.Y[BITS-2:MAN]})
                                + (EXP+2)'(BIAS);
                    end
                end
            end
            DIV: begin
                if (rem_q >= dvs_ext) begin
                    quo_d = {quo_q[MAN:0], 1'b1};
                    rem_d = (rem_q - dvs_ext) << 1;
                end else begin
                    quo_d = {quo_q[MAN:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MAN + 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = DONE;
                flg_d   = '0;
                if (ovf_n) begin
                    res_d          = {sign_q, E_B, {MAN{1'b0}}};
                    flg_d.overflow = 1'b1;
                end else if (unf_n) begin
                    res_d           = {sign_q, {(BITS-1){1'b0}}};
                    flg_d.underflow = 1'b1;
                end else begin
                    res_d = {sign_q, exp_n[EXP-1:0], frac_n};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.result    = res_q;
    assign bus.inf       = flg_q.inf;
    assign bus.nan       = flg_q.nan;
    assign bus.zero      = flg_q.zero;
    assign bus.overflow  = flg_q.overflow;
    assign bus.underflow = flg_q.underflow;

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed vectors, monitor checks result, flags and timing.
module tb_fp_div_seq;

    localparam int L_SPEC = 0;
    localparam int L_NORM = 26;
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_INF  = 5'b10000;
    localparam logic [4:0] F_NAN  = 5'b01000;
    localparam logic [4:0] F_ZERO = 5'b00100;
    localparam logic [4:0] F_OVF  = 5'b00010;
    localparam logic [4:0] F_UNF  = 5'b00001;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int unsigned cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_seq_if #(.EXP(8), .MAN(23)) bus ();

    fp_div_seq #(.EXP(8), .MAN(23)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [4:0] flags_now();
        return {bus.inf, bus.nan, bus.zero, bus.overflow, bus.underflow};
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_flags"}, {27'b0, flags_now()}, {27'b0, e.flg});
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s_idle_timeout: got busy after 100 cycles, expected idle", name);
        end
    endtask

    // Done is sampled on the negedge that follows the DONE-entry edge: cyc + 1 + lat.
    task automatic issue(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] res, input logic [4:0] flg, input int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.X     = x;
        bus.Y     = y;
        sbq.push_back('{res, flg, cyc + 1 + lat, name});
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle(name);
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_busy"},   {31'b0, bus.busy}, 32'h0);
        check({name, "_done"},   {31'b0, bus.done}, 32'h0);
        check({name, "_result"}, bus.result, 32'h0);
        check({name, "_flags"},  {27'b0, flags_now()}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.Y     = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset");

        issue("div_6_2",   32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, L_NORM);
        issue("div_1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NONE, L_NORM);
        issue("div_1_1",   32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE, L_NORM);
        issue("div_10_4",  32'h41200000, 32'h40800000, 32'h40200000, F_NONE, L_NORM);
        issue("div_m6_2",  32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, L_NORM);
        issue("div_1_0",   32'h3F800000, 32'h00000000, 32'h7F800000, F_INF,  L_SPEC);
        issue("div_m1_0",  32'hBF800000, 32'h00000000, 32'hFF800000, F_INF,  L_SPEC);
        issue("div_0_0",   32'h00000000, 32'h00000000, 32'h7FC00000, F_NAN,  L_SPEC);
        issue("div_nan_1", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, F_NAN,  L_SPEC);
        issue("div_inf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, F_NAN, L_SPEC);
        issue("div_inf_2", 32'h7F800000, 32'h40000000, 32'h7F800000, F_INF,  L_SPEC);
        issue("div_0_2",   32'h00000000, 32'h40000000, 32'h00000000, F_ZERO, L_SPEC);
        issue("div_m1_inf", 32'hBF800000, 32'h7F800000, 32'h80000000, F_ZERO, L_SPEC);
        issue("div_ovf",   32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF,  L_NORM);
        issue("div_unf",   32'h00800000, 32'h40000000, 32'h00000000, F_UNF,  L_NORM);

        // Start held for 40 cycles: accepted at step 0 and again at step 28 (first IDLE after DONE).
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b1;
            if (i == 0) begin
                bus.X = 32'h40C00000;
                bus.Y = 32'h40000000;
                sbq.push_back('{32'h40400000, F_NONE, cyc + 1 + L_NORM, "hold_first"});
            end else if (i == 28) begin
                bus.X = 32'h3F800000;
                bus.Y = 32'h40400000;
                sbq.push_back('{32'h3EAAAAAA, F_NONE, cyc + 1 + L_NORM, "hold_second"});
            end else begin
                bus.X = {2'b01, 30'($urandom)};
                bus.Y = {2'b01, 30'($urandom)};
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle("hold");

        @(negedge clk);
        bus.start = 1'b1;
        bus.X     = 32'h40C00000;
        bus.Y     = 32'h40000000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1 check_zero_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        issue("after_abort", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, L_NORM);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
